// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//   SPI responder for DATA_W-bit full-duplex frames, MSB first.
//   The SPI pins are oversampled in the sys_clk domain; no logic runs on SCLK.
//   User side: a one-deep TX holding register with a valid/ready handshake, and
//   a one-cycle strobe for every completed RX frame.
//
// Ports
//   sys_clk      system clock (SCLK must be at most sys_clk/8)
//   rst          synchronous, active-high reset
//   spi_mode     {CPOL,CPHA}, captured when a frame starts
//   tx_data      word for the next frame, accepted when tx_valid && tx_ready
//   tx_valid     tx_data is valid
//   tx_ready     holding register is empty (also high while it is being emptied)
//   rx_data      last received word, held until the next completed frame
//   rx_valid     one-cycle pulse: rx_data was just updated
//   tx_underrun  one-cycle pulse: a frame started with no TX word loaded
//   frame_err    one-cycle pulse: CSN rose before a full frame was received
//   spi_csn      chip select from the master, active low
//   spi_clk      SCLK from the master
//   spi_mosi     master-to-slave data
//   spi_miso     slave-to-master data
//   spi_miso_oe  MISO output enable, high while a frame is selected
// -----------------------------------------------------------------------------
module spi_slave #(
   parameter int                DATA_W     = 16,
   parameter logic [DATA_W-1:0] DEFAULT_TX = '0
) (
   input  logic              sys_clk,
   input  logic              rst,
   input  logic [1:0]        spi_mode,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              tx_underrun,
   output logic              frame_err,
   input  logic              spi_csn,
   input  logic              spi_clk,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic              spi_miso_oe
);

   localparam int CNT_W = $clog2(DATA_W) + 1;
   localparam int PIN_CSN  = 0;
   localparam int PIN_SCLK = 1;
   localparam int PIN_MOSI = 2;
   // Idle levels the synchronisers come out of reset with: CSN=1, SCLK=0, MOSI=0
   localparam logic [2:0] PIN_RST = 3'b001;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SHIFT   = 2'd1,
      ST_DONE    = 2'd2,
      ST_WAIT_CS = 2'd3
   } state_t;

   // ------------------------------------------------------------------------
   // Pin synchronisers: two flops per pin, plus a delayed copy for edge detect
   // ------------------------------------------------------------------------
   logic [2:0] pins_raw;
   logic [2:0] pins_sync;
   logic [2:0] pins_prev;

   assign pins_raw = {spi_mosi, spi_clk, spi_csn};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_sync
         logic meta_reg;
         logic sync_reg;
         logic prev_reg;

         always_ff @(posedge sys_clk) begin
            if (rst) begin
               meta_reg <= PIN_RST[gi];
               sync_reg <= PIN_RST[gi];
               prev_reg <= PIN_RST[gi];
            end else begin
               meta_reg <= pins_raw[gi];
               sync_reg <= meta_reg;
               prev_reg <= sync_reg;
            end
         end

         assign pins_sync[gi] = sync_reg;
         assign pins_prev[gi] = prev_reg;
      end
   endgenerate

   logic csn_s;
   logic mosi_s;
   logic csn_fall;
   logic csn_rise;
   logic sclk_rise;
   logic sclk_fall;

   assign csn_s     = pins_sync[PIN_CSN];
   assign mosi_s    = pins_sync[PIN_MOSI];
   assign csn_fall  =  pins_prev[PIN_CSN]  & ~pins_sync[PIN_CSN];
   assign csn_rise  = ~pins_prev[PIN_CSN]  &  pins_sync[PIN_CSN];
   assign sclk_rise = ~pins_prev[PIN_SCLK] &  pins_sync[PIN_SCLK];
   assign sclk_fall =  pins_prev[PIN_SCLK] & ~pins_sync[PIN_SCLK];

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_t             state_reg,       state_next;
   logic [1:0]         mode_reg,        mode_next;
   logic [DATA_W-1:0]  tx_shreg_reg,    tx_shreg_next;
   logic [DATA_W-1:0]  rx_shreg_reg,    rx_shreg_next;
   logic [CNT_W-1:0]   bit_cnt_reg,     bit_cnt_next;
   logic [DATA_W-1:0]  hold_reg,        hold_next;
   logic               hold_full_reg,   hold_full_next;
   logic [DATA_W-1:0]  rx_data_reg,     rx_data_next;
   logic               rx_valid_reg,    rx_valid_next;
   logic               underrun_reg,    underrun_next;
   logic               frame_err_reg,   frame_err_next;
   logic               miso_reg,        miso_next;
   logic               oe_reg,          oe_next;
   logic [1:0]         flush_reg,       flush_next;
   logic               armed_reg,       armed_next;

   logic copy_now;
   logic tx_load;
   logic lead_edge;
   logic trail_edge;
   logic sample_edge;
   logic shift_edge;
   logic last_sample;
   logic [DATA_W-1:0] start_word;

   // Edge roles follow the mode captured at frame start
   assign lead_edge   = mode_reg[1] ? sclk_fall : sclk_rise;
   assign trail_edge  = mode_reg[1] ? sclk_rise : sclk_fall;
   assign sample_edge = mode_reg[0] ? trail_edge : lead_edge;
   assign shift_edge  = mode_reg[0] ? lead_edge  : trail_edge;
   assign last_sample = sample_edge && (bit_cnt_reg == CNT_W'(DATA_W - 1));
   assign start_word  = hold_full_reg ? hold_reg : DEFAULT_TX;

   // The register reads as empty in the cycle it is copied, so a word offered
   // in that same cycle lands in the freshly emptied register.
   assign tx_ready = ~hold_full_reg | copy_now;
   assign tx_load  = tx_valid & tx_ready;

   always_comb begin
      state_next     = state_reg;
      mode_next      = mode_reg;
      tx_shreg_next  = tx_shreg_reg;
      rx_shreg_next  = rx_shreg_reg;
      bit_cnt_next   = bit_cnt_reg;
      hold_next      = hold_reg;
      hold_full_next = hold_full_reg;
      rx_data_next   = rx_data_reg;
      rx_valid_next  = 1'b0;
      underrun_next  = 1'b0;
      frame_err_next = 1'b0;
      miso_next      = miso_reg;
      oe_next        = oe_reg;
      copy_now       = 1'b0;
      // Only a CSN high level seen after reset arms frame detection, so a
      // CSN that was already low when reset hit cannot start a frame.
      flush_next     = {flush_reg[0], 1'b1};
      armed_next     = armed_reg | (flush_reg[1] & csn_s);

      case (state_reg)
         ST_IDLE: begin
            oe_next = 1'b0;
            if (armed_reg && csn_fall) begin
               state_next    = ST_SHIFT;
               mode_next     = spi_mode;
               copy_now      = 1'b1;
               tx_shreg_next = start_word;
               underrun_next = ~hold_full_reg;
               rx_shreg_next = '0;
               bit_cnt_next  = '0;
               // MSB is on the pin before the first SCLK edge, which is what a
               // CPHA=0 master samples on its lead edge.
               miso_next     = start_word[DATA_W-1];
               oe_next       = 1'b1;
            end
         end

         ST_SHIFT: begin
            if (sample_edge) begin
               rx_shreg_next = {rx_shreg_reg[DATA_W-2:0], mosi_s};
               bit_cnt_next  = bit_cnt_reg + CNT_W'(1);
            end
            if (shift_edge) begin
               if (mode_reg[0]) begin
                  // CPHA=1: each lead edge presents the current bit, MSB first
                  miso_next = tx_shreg_reg[DATA_W-1];
               end else begin
                  // CPHA=0: MSB already presented at start, trail edges move on
                  miso_next = tx_shreg_reg[DATA_W-2];
               end
               tx_shreg_next = tx_shreg_reg << 1;
            end
            // A final sample coinciding with CSN rise still completes the frame
            if (last_sample) begin
               state_next = ST_DONE;
            end else if (csn_rise) begin
               state_next     = ST_IDLE;
               frame_err_next = 1'b1;
               oe_next        = 1'b0;
               miso_next      = 1'b0;
            end
         end

         ST_DONE: begin
            rx_data_next  = rx_shreg_reg;
            rx_valid_next = 1'b1;
            state_next    = ST_WAIT_CS;
         end

         ST_WAIT_CS: begin
            // Level check: CSN may already have risen while in DONE
            if (csn_s) begin
               state_next = ST_IDLE;
               oe_next    = 1'b0;
               miso_next  = 1'b0;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase

      if (copy_now) begin
         hold_full_next = 1'b0;
      end
      if (tx_load) begin
         hold_next      = tx_data;
         hold_full_next = 1'b1;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         mode_reg      <= 2'b00;
         tx_shreg_reg  <= '0;
         rx_shreg_reg  <= '0;
         bit_cnt_reg   <= '0;
         hold_reg      <= '0;
         hold_full_reg <= 1'b0;
         rx_data_reg   <= '0;
         rx_valid_reg  <= 1'b0;
         underrun_reg  <= 1'b0;
         frame_err_reg <= 1'b0;
         miso_reg      <= 1'b0;
         oe_reg        <= 1'b0;
         flush_reg     <= 2'b00;
         armed_reg     <= 1'b0;
      end else begin
         state_reg     <= state_next;
         mode_reg      <= mode_next;
         tx_shreg_reg  <= tx_shreg_next;
         rx_shreg_reg  <= rx_shreg_next;
         bit_cnt_reg   <= bit_cnt_next;
         hold_reg      <= hold_next;
         hold_full_reg <= hold_full_next;
         rx_data_reg   <= rx_data_next;
         rx_valid_reg  <= rx_valid_next;
         underrun_reg  <= underrun_next;
         frame_err_reg <= frame_err_next;
         miso_reg      <= miso_next;
         oe_reg        <= oe_next;
         flush_reg     <= flush_next;
         armed_reg     <= armed_next;
      end
   end

   assign rx_data     = rx_data_reg;
   assign rx_valid    = rx_valid_reg;
   assign tx_underrun = underrun_reg;
   assign frame_err   = frame_err_reg;
   assign spi_miso    = miso_reg;
   assign spi_miso_oe = oe_reg;

endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
//   Drives spi_slave as an SPI master and checks it against a frame-level
//   model: a one-deep TX holding register, a queue of words expected on
//   rx_valid, and running totals of expected underrun / frame error pulses.
// -----------------------------------------------------------------------------
module tb_spi_slave;

   localparam int          DATA_W     = 16;
   localparam logic [15:0] DEFAULT_TX = 16'h0000;
   localparam int          HALF       = 8;     // sys_clk cycles per SCLK half period

   logic        sys_clk = 1'b0;
   logic        rst     = 1'b1;
   logic [1:0]  spi_mode = 2'b00;
   logic [15:0] tx_data = 16'h0000;
   logic        tx_valid = 1'b0;
   logic        tx_ready;
   logic [15:0] rx_data;
   logic        rx_valid;
   logic        tx_underrun;
   logic        frame_err;
   logic        spi_csn  = 1'b1;
   logic        spi_clk  = 1'b0;
   logic        spi_mosi = 1'b0;
   logic        spi_miso;
   logic        spi_miso_oe;

   spi_slave #(.DATA_W(DATA_W), .DEFAULT_TX(DEFAULT_TX)) dut (
      .sys_clk     (sys_clk),
      .rst         (rst),
      .spi_mode    (spi_mode),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .tx_underrun (tx_underrun),
      .frame_err   (frame_err),
      .spi_csn     (spi_csn),
      .spi_clk     (spi_clk),
      .spi_mosi    (spi_mosi),
      .spi_miso    (spi_miso),
      .spi_miso_oe (spi_miso_oe)
   );

   always #10 sys_clk = ~sys_clk;

   // ---------------- model state ----------------
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] model_rx        = 16'h0000;
   logic        model_hold_full = 1'b0;
   logic [15:0] model_hold      = 16'h0000;
   int          exp_und  = 0;
   int          exp_err  = 0;
   int          seen_und = 0;
   int          seen_err = 0;
   logic [15:0] exp_q[$];
   logic [15:0] mon_w;
   logic [15:0] rd_word;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   // Per-cycle compare, sampled 3 ns after the active edge
   always @(posedge sys_clk) begin
      #3;
      if (!rst) begin
         if (tx_underrun) seen_und++;
         if (frame_err)   seen_err++;
         if (rx_valid) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL rx_valid_unexpected: got pulse with rx_data 0x%0h, required no pulse", rx_data);
            end else begin
               mon_w = exp_q.pop_front();
               chk("rx_data_on_valid", rx_data, mon_w);
               model_rx = mon_w;
            end
         end else begin
            chk("rx_data_held", rx_data, model_rx);
         end
      end
   end

   task automatic load_tx(input logic [15:0] w);
      logic acc;
      @(negedge sys_clk);
      chk("tx_ready_before_load", tx_ready, !model_hold_full);
      acc      = !model_hold_full;
      tx_data  = w;
      tx_valid = 1'b1;
      @(negedge sys_clk);
      tx_valid = 1'b0;
      if (acc) begin
         model_hold      = w;
         model_hold_full = 1'b1;
      end
      chk("tx_ready_after_load", tx_ready, !model_hold_full);
   endtask

   task automatic check_reset_values();
      chk("rst_tx_ready", tx_ready, 1);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_tx_underrun", tx_underrun, 0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_miso", spi_miso, 0);
      chk("rst_miso_oe", spi_miso_oe, 0);
   endtask

   // One master transaction. nbits<16 aborts; rst_at>=0 pulses rst before
   // that bit; load_at>=0 offers load_w during that bit.
   task automatic frame(input logic [1:0] mode, input logic [15:0] mosi_w, input int nbits,
                        input int load_at, input logic [15:0] load_w, input int rst_at,
                        output logic [15:0] miso_w);
      logic        cpha;
      logic [15:0] exp_tx;
      logic        was_rst;
      logic        full;
      cpha    = mode[0];
      was_rst = 1'b0;
      full    = (nbits == 16);
      miso_w  = 16'h0000;
      exp_tx  = model_hold_full ? model_hold : DEFAULT_TX;
      if (!model_hold_full) exp_und++;
      model_hold_full = 1'b0;

      spi_mode = mode;
      spi_clk  = mode[1];
      spi_mosi = cpha ? 1'b0 : mosi_w[15];
      clks(2);
      spi_csn = 1'b0;
      clks(HALF);
      chk("tx_ready_after_start", tx_ready, !model_hold_full);

      for (int i = 0; i < nbits; i++) begin
         if (i == rst_at) begin
            rst = 1'b1;
            model_rx = 16'h0000;
            model_hold_full = 1'b0;
            exp_q.delete();
            clks(1);
            check_reset_values();
            rst = 1'b0;
            was_rst = 1'b1;
         end
         if (!cpha) begin
            if (full && !was_rst && i == 15) exp_q.push_back(mosi_w);
            chk("miso_oe_at_sample", spi_miso_oe, !was_rst);
            miso_w[15-i] = spi_miso;
            spi_clk = ~spi_clk;
            if (i == load_at) begin load_tx(load_w); clks(HALF - 2); end
            else clks(HALF);
            spi_clk = ~spi_clk;
            if (i < 15) spi_mosi = mosi_w[14-i];
            clks(HALF);
         end else begin
            spi_clk  = ~spi_clk;
            spi_mosi = mosi_w[15-i];
            if (i == load_at) begin load_tx(load_w); clks(HALF - 2); end
            else clks(HALF);
            if (full && !was_rst && i == 15) exp_q.push_back(mosi_w);
            chk("miso_oe_at_sample", spi_miso_oe, !was_rst);
            miso_w[15-i] = spi_miso;
            spi_clk = ~spi_clk;
            clks(HALF);
         end
      end
      if (full && !was_rst) chk("rx_valid_within_bound", exp_q.size(), 0);
      clks(HALF);
      spi_csn = 1'b1;
      if (!full && !was_rst) exp_err++;
      clks(8);
      chk("miso_oe_idle", spi_miso_oe, 0);
      chk("underrun_count", seen_und, exp_und);
      chk("frame_err_count", seen_err, exp_err);
      chk("tx_ready_idle", tx_ready, !model_hold_full);
      if (full && !was_rst) chk("master_read_word", miso_w, exp_tx);
   endtask

   initial begin
      #20_000_000;
      $display("FAIL watchdog: got no finish, required finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      clks(4);
      check_reset_values();
      rst = 1'b0;
      clks(6);

      // 1: mode 3, preloaded word
      load_tx(16'h1234);
      frame(2'd3, 16'hA5C3, 16, -1, 16'h0, -1, rd_word);
      chk("t1_master_read", rd_word, 16'h1234);
      chk("t1_rx_data", rx_data, 16'hA5C3);
      chk("t1_tx_ready", tx_ready, 1);

      // 2: modes 1, 0, 2
      for (int m = 0; m < 3; m++) begin
         logic [1:0] md;
         md = (m == 0) ? 2'd1 : ((m == 1) ? 2'd0 : 2'd2);
         load_tx(16'h8001);
         frame(md, 16'h7FFE, 16, -1, 16'h0, -1, rd_word);
         chk("t2_master_read", rd_word, 16'h8001);
         chk("t2_rx_data", rx_data, 16'h7FFE);
      end

      // 3: no preload -> underrun, default word
      frame(2'd0, 16'h1357, 16, -1, 16'h0, -1, rd_word);
      chk("t3_master_read", rd_word, 16'h0000);
      chk("t3_rx_data", rx_data, 16'h1357);

      // 4: abort after 7 SCLK, then full frame
      load_tx(16'h4242);
      frame(2'd0, 16'hFFFF, 7, -1, 16'h0, -1, rd_word);
      chk("t4_rx_unchanged", rx_data, 16'h1357);
      frame(2'd0, 16'h00FF, 16, -1, 16'h0, -1, rd_word);
      chk("t4_rx_data", rx_data, 16'h00FF);
      chk("t4_master_read_default", rd_word, 16'h0000);

      // 5: back-to-back, word loaded mid-frame used next
      load_tx(16'h1111);
      frame(2'd1, 16'h0F0F, 16, 4, 16'h2222, -1, rd_word);
      chk("t5_first_read", rd_word, 16'h1111);
      clks(16 * HALF - 8);
      frame(2'd1, 16'hF0F0, 16, -1, 16'h0, -1, rd_word);
      chk("t5_second_read", rd_word, 16'h2222);

      // 6: reset after bit 9, then 0xBEEF
      load_tx(16'hCAFE);
      frame(2'd0, 16'h5555, 16, -1, 16'h0, 9, rd_word);
      chk("t6_rx_after_rst", rx_data, 16'h0000);
      frame(2'd0, 16'hBEEF, 16, -1, 16'h0, -1, rd_word);
      chk("t6_rx_data", rx_data, 16'hBEEF);

      // Randomized frames
      for (int r = 0; r < 40; r++) begin
         logic [1:0]  md;
         logic [15:0] w;
         int          nb;
         int          la;
         md = 2'($urandom_range(0, 3));
         w  = 16'($urandom);
         nb = ($urandom_range(0, 99) < 15) ? int'($urandom_range(1, 15)) : 16;
         la = (nb > 5 && $urandom_range(0, 99) < 30) ? 3 : -1;
         if ($urandom_range(0, 1) == 1 && !model_hold_full) load_tx(16'($urandom));
         frame(md, w, nb, la, 16'($urandom), -1, rd_word);
         clks(int'($urandom_range(2, 40)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
